// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass, busy scoreboard and post-reset clear sequencer.
// Latency: reads are combinational; writes and reservations land on the next rising edge; INIT lasts DEPTH edges.
// Backpressure: none; writes and reserves presented while Ready is low are dropped.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ResvReg,
    input  logic              ResvEn,
    output logic              Ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic              ready_q;
    logic [DEPTH-1:0]  busy_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              wr_en;
    logic              resv_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign clr_cnt_d = clr_cnt_q + 1'b1;
    assign wr_en   = ready_q && RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));
    assign resv_en = ready_q && ResvEn   && !((ZERO_REG != 0) && (ResvReg  == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_d;
                    if (&clr_cnt_q) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Reserve is applied last so a same-cycle reservation outlives the write's clear.
                    if (wr_en)   busy_q[WriteReg] <= 1'b0;
                    if (resv_en) busy_q[ResvReg]  <= 1'b1;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Storage has no reset; the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            regs_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[WriteReg] <= WriteData;
        end
    end

    assign rd_addr[0] = ReadReg1;
    assign rd_addr[1] = ReadReg2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (!ready_q || ((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if ((BYPASS != 0) && RegWrite && (WriteReg == rd_addr[p])) begin
                rd_data[p] = WriteData;
                rd_busy[p] = (ResvEn && (ResvReg == rd_addr[p])) ? busy_q[rd_addr[p]] : 1'b0;
            end else begin
                rd_data[p] = regs_q[rd_addr[p]];
                rd_busy[p] = busy_q[rd_addr[p]];
            end
        end
    end

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign Busy1     = rd_busy[0];
    assign Busy2     = rd_busy[1];
    assign Ready     = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance plus a ZERO_REG=0 instance on shared inputs.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg, ResvReg;
    logic [31:0] WriteData;
    logic        RegWrite, ResvEn;
    logic [31:0] ReadData1, ReadData2, nz_ReadData1, nz_ReadData2;
    logic        Busy1, Busy2, nz_Busy1, nz_Busy2, Ready, nz_Ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .Busy1(Busy1), .Busy2(Busy2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ResvReg(ResvReg), .ResvEn(ResvEn), .Ready(Ready)
    );

    regfile_scoreboard #(.ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(nz_ReadData1), .ReadData2(nz_ReadData2), .Busy1(nz_Busy1), .Busy2(nz_Busy2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ResvReg(ResvReg), .ResvEn(ResvEn), .Ready(nz_Ready)
    );

    task automatic idle_inputs();
        RegWrite = 1'b0; ResvEn = 1'b0; WriteReg = '0; ResvReg = '0;
        WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
    endtask

    // Releases reset on a falling edge and counts rising edges until Ready.
    task automatic release_and_count(output int edges);
        edges = 0;
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (Ready) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (Ready !== 1'b0 || ReadData1 !== 32'h0 || Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: Ready=%b RD1=%h Busy1=%b required 0/0/0", Ready, ReadData1, Busy1);
        end
        @(negedge clk);
        release_and_count(edges);
        n_checks++;
        if (edges != 32) begin
            n_fail++;
            $display("FAIL init_length: Ready after %0d edges, required 32", edges);
        end
        n_checks++;
        if (nz_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_length_nz: Ready=%b required 1", nz_Ready);
        end
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(31 - a);
            #1;
            n_checks++;
            if (ReadData1 !== 32'h0 || Busy1 !== 1'b0 || ReadData2 !== 32'h0 || Busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL cleared_r%0d: RD1=%h B1=%b RD2=%h B2=%b required all 0",
                         a, ReadData1, Busy1, ReadData2, Busy2);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle_inputs();
        WriteReg = 5'd5; WriteData = 32'hDEADBEEF; RegWrite = 1'b1;
        ReadReg1 = 5'd5; ReadReg2 = 5'd6;
        #1;
        n_checks++;
        if (ReadData1 !== 32'hDEADBEEF || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: RD1=%h RD2=%h required deadbeef/0", ReadData1, ReadData2);
        end
        @(posedge clk); #1;
        RegWrite = 1'b0; WriteData = 32'h0;
        #1;
        n_checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_after_edge: RD1=%h required deadbeef", ReadData1);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle_inputs();
        WriteReg = 5'd0; WriteData = 32'h12345678; RegWrite = 1'b1;
        ResvReg = 5'd0; ResvEn = 1'b1; ReadReg1 = 5'd0;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || nz_ReadData1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL zero_bypass: RD1=%h nzRD1=%h required 0/12345678", ReadData1, nz_ReadData1);
        end
        @(posedge clk); #1;
        RegWrite = 1'b0; ResvEn = 1'b0;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_hardwired: RD1=%h Busy1=%b required 0/0", ReadData1, Busy1);
        end
        n_checks++;
        if (nz_ReadData1 !== 32'h12345678 || nz_Busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ordinary: RD1=%h Busy1=%b required 12345678/1", nz_ReadData1, nz_Busy1);
        end
    endtask

    task automatic test_resv_write_same();
        @(negedge clk);
        idle_inputs();
        ResvReg = 5'd7; ResvEn = 1'b1; ReadReg1 = 5'd7;
        #1;
        n_checks++;
        if (Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL resv_before_edge: Busy1=%b required 0", Busy1);
        end
        @(posedge clk); #1;
        ResvEn = 1'b0;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL resv_after_edge: Busy1=%b required 1", Busy1);
        end
        @(negedge clk);
        WriteReg = 5'd7; WriteData = 32'h0BADF00D; RegWrite = 1'b1; ResvEn = 1'b1;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1 || ReadData1 !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL resv_write_same_cycle: Busy1=%b RD1=%h required 1/0badf00d", Busy1, ReadData1);
        end
        @(posedge clk); #1;
        RegWrite = 1'b0; ResvEn = 1'b0;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1 || ReadData1 !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL resv_write_after: Busy1=%b RD1=%h required 1/0badf00d", Busy1, ReadData1);
        end
        @(negedge clk);
        WriteData = 32'h00C0FFEE; RegWrite = 1'b1;
        #1;
        n_checks++;
        if (Busy1 !== 1'b0 || ReadData1 !== 32'h00C0FFEE) begin
            n_fail++;
            $display("FAIL busy_bypass_clear: Busy1=%b RD1=%h required 0/00c0ffee", Busy1, ReadData1);
        end
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        n_checks++;
        if (Busy1 !== 1'b0 || ReadData1 !== 32'h00C0FFEE) begin
            n_fail++;
            $display("FAIL busy_cleared: Busy1=%b RD1=%h required 0/00c0ffee", Busy1, ReadData1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle_inputs();
        WriteReg = 5'd10; WriteData = 32'h11110000; RegWrite = 1'b1;
        @(negedge clk);
        WriteReg = 5'd11; WriteData = 32'h22220000;
        ReadReg1 = 5'd10; ReadReg2 = 5'd11;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h11110000 || ReadData2 !== 32'h22220000) begin
            n_fail++;
            $display("FAIL b2b_mixed: RD1=%h RD2=%h required 11110000/22220000", ReadData1, ReadData2);
        end
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h11110000 || ReadData2 !== 32'h22220000) begin
            n_fail++;
            $display("FAIL b2b_array: RD1=%h RD2=%h required 11110000/22220000", ReadData1, ReadData2);
        end
    endtask

    task automatic test_reset_midrun();
        int edges;
        @(negedge clk);
        idle_inputs();
        WriteReg = 5'd3; WriteData = 32'hA5A5A5A5; RegWrite = 1'b1; ReadReg1 = 5'd3;
        @(negedge clk);
        RegWrite = 1'b0; ResvReg = 5'd3; ResvEn = 1'b1;
        @(negedge clk);
        ResvEn = 1'b0;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1 || ReadData1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL pre_reset_state: Busy1=%b RD1=%h required 1/a5a5a5a5", Busy1, ReadData1);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (Ready !== 1'b0 || Busy1 !== 1'b0 || ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: Ready=%b Busy1=%b RD1=%h required 0/0/0", Ready, Busy1, ReadData1);
        end
        @(negedge clk);
        release_and_count(edges);
        n_checks++;
        if (edges != 32) begin
            n_fail++;
            $display("FAIL reinit_length: Ready after %0d edges, required 32", edges);
        end
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r3_cleared: RD1=%h Busy1=%b required 0/0", ReadData1, Busy1);
        end
    endtask

    task automatic test_init_write();
        int edges;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        ReadReg1 = 5'd9;
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 10) begin
                WriteReg = 5'd9; WriteData = 32'hFFFF0009; RegWrite = 1'b1;
                ResvReg = 5'd9; ResvEn = 1'b1;
                #1;
                n_checks++;
                if (ReadData1 !== 32'h0 || Busy1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_reads_forced: RD1=%h Busy1=%b required 0/0", ReadData1, Busy1);
                end
            end
            @(posedge clk); #1;
            if (e == 12) begin
                RegWrite = 1'b0; ResvEn = 1'b0;
            end
            if (Ready) begin
                edges = e;
                break;
            end
        end
        n_checks++;
        if (edges != 32) begin
            n_fail++;
            $display("FAIL init_write_length: Ready after %0d edges, required 32", edges);
        end
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || Busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL init_write_ignored: RD1=%h Busy1=%b required 0/0", ReadData1, Busy1);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_resv_write_same();
        test_back_to_back();
        test_reset_midrun();
        test_init_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
